// File: rtl/cmd_frame_decoder_if.sv
// Frame bus between the channel synchronizer and the command decoder.
//   SyncData      16-bit frame, meaningful only while SyncDataLoad is high
//   SyncDataLoad  one-cycle frame-valid pulse
// Handshake: a frame transfers on every clk where SyncDataLoad=1; there is no
// back-pressure, so the receiver must accept every qualified frame.
// master: synchronizer side (drives), slave: decoder side (receives).
interface cmd_frame_decoder_if;
    logic [15:0] SyncData;
    logic        SyncDataLoad;

    modport master (output SyncData, output SyncDataLoad);
    modport slave  (input  SyncData, input  SyncDataLoad);
endinterface

// File: rtl/cmd_frame_decoder.sv
// RD53A command frame decoder.
// Turns 16-bit frames into single-cycle command strobes plus payload fields.
// Ports:
//   clk, Reset       command clock, synchronous active-high reset
//   frm              frame bus (SyncData / SyncDataLoad)
//   Locked           channel lock; while low the decoder idles and ignores frames
//   ChipId           this chip's id for command addressing
//   ClrErrCnt        clears ErrCnt (wins over a same-cycle increment)
//   Trig*/Ecr/Bcr/Pulse/Cal/WrReg/RdReg strobes and fields, registered
//   ErrCnt           saturating decode-error count
//   fsm_state        debug view of the FSM (0=IDLE, 1=COLLECT)
module cmd_frame_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 Reset,
    cmd_frame_decoder_if.slave   frm,
    input  logic                 Locked,
    input  logic [2:0]           ChipId,
    input  logic                 ClrErrCnt,
    output logic                 TrigValid,
    output logic [3:0]           TrigPattern,
    output logic [4:0]           TrigTag,
    output logic                 EcrStb,
    output logic                 BcrStb,
    output logic                 PulseStb,
    output logic [3:0]           PulseDur,
    output logic                 CalStb,
    output logic [14:0]          CalData,
    output logic                 WrRegStb,
    output logic                 RdRegStb,
    output logic [8:0]           RegAddr,
    output logic [15:0]          RegData,
    output logic [ERR_CNT_W-1:0] ErrCnt,
    output logic                 fsm_state
);
    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
    typedef enum logic [1:0] {CMD_PULSE, CMD_CAL, CMD_RDREG, CMD_WRREG} cmd_t;

    // {valid, value} for a data symbol
    function automatic logic [5:0] data_dec(input logic [7:0] b);
        case (b)
            8'h6A: return 6'h20; 8'h6C: return 6'h21; 8'h71: return 6'h22; 8'h72: return 6'h23;
            8'h74: return 6'h24; 8'h8B: return 6'h25; 8'h8D: return 6'h26; 8'h8E: return 6'h27;
            8'h93: return 6'h28; 8'h95: return 6'h29; 8'h96: return 6'h2A; 8'h99: return 6'h2B;
            8'h9A: return 6'h2C; 8'h9C: return 6'h2D; 8'hA3: return 6'h2E; 8'hA5: return 6'h2F;
            8'hA6: return 6'h30; 8'hA9: return 6'h31; 8'hAA: return 6'h32; 8'hAC: return 6'h33;
            8'hB1: return 6'h34; 8'hB2: return 6'h35; 8'hB4: return 6'h36; 8'hC3: return 6'h37;
            8'hC5: return 6'h38; 8'hC6: return 6'h39; 8'hC9: return 6'h3A; 8'hCA: return 6'h3B;
            8'hCC: return 6'h3C; 8'hD1: return 6'h3D; 8'hD2: return 6'h3E; 8'hD4: return 6'h3F;
            default: return 6'h00;
        endcase
    endfunction

    // Trigger pattern 1..15; 0 means "not a trigger symbol"
    function automatic logic [3:0] trig_dec(input logic [7:0] b);
        case (b)
            8'h2B: return 4'd1;  8'h2D: return 4'd2;  8'h2E: return 4'd3;  8'h33: return 4'd4;
            8'h35: return 4'd5;  8'h36: return 4'd6;  8'h39: return 4'd7;  8'h3A: return 4'd8;
            8'h3C: return 4'd9;  8'h4B: return 4'd10; 8'h4D: return 4'd11; 8'h4E: return 4'd12;
            8'h53: return 4'd13; 8'h55: return 4'd14; 8'h56: return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    state_t      state, state_n;
    cmd_t        cmd, cmd_n;
    logic [1:0]  cnt, cnt_n;      // payload frames received so far
    logic [29:0] pay, pay_n;
    logic        trig_n, ecr_n, bcr_n, pulse_n, cal_n, wr_n, rd_n, err_inc;
    logic [3:0]  trig_pat_n, pulse_dur_n;
    logic [4:0]  trig_tag_n, sym0;
    logic [14:0] cal_data_n;
    logic [8:0]  reg_addr_n;
    logic [15:0] reg_data_n;
    logic [5:0]  hi_d, lo_d;
    logic [3:0]  hi_t;
    logic [29:0] shifted;
    logic [1:0]  last_idx;
    logic        is_hdr;

    assign hi_d    = data_dec(frm.SyncData[15:8]);
    assign lo_d    = data_dec(frm.SyncData[7:0]);
    assign hi_t    = trig_dec(frm.SyncData[15:8]);
    assign shifted = {pay[19:0], hi_d[4:0], lo_d[4:0]};
    assign is_hdr  = (frm.SyncData == 16'h5A5A) || (frm.SyncData == 16'h5959) ||
                     (frm.SyncData == 16'h5C5C) || (frm.SyncData == 16'h6363) ||
                     (frm.SyncData == 16'h6666) || (frm.SyncData == 16'h6565);
    assign fsm_state = state;

    always_comb begin
        state_n     = state;
        cmd_n       = cmd;
        cnt_n       = cnt;
        pay_n       = pay;
        trig_n      = 1'b0;
        ecr_n       = 1'b0;
        bcr_n       = 1'b0;
        pulse_n     = 1'b0;
        cal_n       = 1'b0;
        wr_n        = 1'b0;
        rd_n        = 1'b0;
        err_inc     = 1'b0;
        trig_pat_n  = TrigPattern;
        trig_tag_n  = TrigTag;
        pulse_dur_n = PulseDur;
        cal_data_n  = CalData;
        reg_addr_n  = RegAddr;
        reg_data_n  = RegData;

        // Index of the final payload frame and the address symbol position
        // inside the assembled payload for the command being collected.
        case (cmd)
            CMD_PULSE: begin last_idx = 2'd0; sym0 = shifted[9:5];   end
            CMD_CAL:   begin last_idx = 2'd1; sym0 = shifted[19:15]; end
            CMD_RDREG: begin last_idx = 2'd1; sym0 = shifted[19:15]; end
            default:   begin last_idx = 2'd2; sym0 = shifted[29:25]; end
        endcase

        if (!Locked) begin
            state_n = IDLE;
            cnt_n   = 2'd0;
        end else if (frm.SyncDataLoad) begin
            if (is_hdr) begin
                // A new header always wins; an unfinished command is an error.
                if (state == COLLECT) err_inc = 1'b1;
                cnt_n = 2'd0;
                pay_n = '0;
                case (frm.SyncData)
                    16'h5A5A: begin ecr_n = 1'b1; state_n = IDLE; end
                    16'h5959: begin bcr_n = 1'b1; state_n = IDLE; end
                    16'h5C5C: begin cmd_n = CMD_PULSE; state_n = COLLECT; end
                    16'h6363: begin cmd_n = CMD_CAL;   state_n = COLLECT; end
                    16'h6565: begin cmd_n = CMD_RDREG; state_n = COLLECT; end
                    default:  begin cmd_n = CMD_WRREG; state_n = COLLECT; end
                endcase
            end else if (hi_t != 4'd0 && lo_d[5]) begin
                trig_n     = 1'b1;
                trig_pat_n = hi_t;
                trig_tag_n = lo_d[4:0];
            end else if (frm.SyncData == 16'h6969 || frm.SyncData == 16'h817E) begin
                // NOOP / SYNC: no effect, collection progress kept
            end else if (hi_d[5] && lo_d[5]) begin
                if (state == IDLE) begin
                    err_inc = 1'b1;
                end else begin
                    pay_n = shifted;
                    if (cnt == last_idx) begin
                        state_n = IDLE;
                        cnt_n   = 2'd0;
                        if (sym0[4] || (sym0[3:1] == ChipId)) begin
                            case (cmd)
                                CMD_PULSE: begin pulse_n = 1'b1; pulse_dur_n = shifted[3:0]; end
                                CMD_CAL:   begin cal_n = 1'b1; cal_data_n = shifted[14:0]; end
                                CMD_RDREG: begin rd_n = 1'b1; reg_addr_n = shifted[14:6]; end
                                default: begin
                                    // Long write (mode=1) is not supported
                                    if (sym0[0]) begin
                                        err_inc = 1'b1;
                                    end else begin
                                        wr_n       = 1'b1;
                                        reg_addr_n = shifted[24:16];
                                        reg_data_n = shifted[15:0];
                                    end
                                end
                            endcase
                        end
                    end else begin
                        cnt_n = cnt + 2'd1;
                    end
                end
            end else begin
                err_inc = 1'b1;
                state_n = IDLE;
                cnt_n   = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            cmd         <= CMD_PULSE;
            cnt         <= 2'd0;
            pay         <= '0;
            TrigValid   <= 1'b0;
            TrigPattern <= 4'd0;
            TrigTag     <= 5'd0;
            EcrStb      <= 1'b0;
            BcrStb      <= 1'b0;
            PulseStb    <= 1'b0;
            PulseDur    <= 4'd0;
            CalStb      <= 1'b0;
            CalData     <= 15'd0;
            WrRegStb    <= 1'b0;
            RdRegStb    <= 1'b0;
            RegAddr     <= 9'd0;
            RegData     <= 16'd0;
            ErrCnt      <= '0;
        end else begin
            state       <= state_n;
            cmd         <= cmd_n;
            cnt         <= cnt_n;
            pay         <= pay_n;
            TrigValid   <= trig_n;
            TrigPattern <= trig_pat_n;
            TrigTag     <= trig_tag_n;
            EcrStb      <= ecr_n;
            BcrStb      <= bcr_n;
            PulseStb    <= pulse_n;
            PulseDur    <= pulse_dur_n;
            CalStb      <= cal_n;
            CalData     <= cal_data_n;
            WrRegStb    <= wr_n;
            RdRegStb    <= rd_n;
            RegAddr     <= reg_addr_n;
            RegData     <= reg_data_n;
            if (ClrErrCnt)
                ErrCnt <= '0;
            else if (err_inc && !(&ErrCnt))
                ErrCnt <= ErrCnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed testbench for cmd_frame_decoder: frames are sent 16 clk apart,
// outputs are sampled on the falling edge following the load cycle.
module tb_cmd_frame_decoder;
    logic        clk = 1'b0;
    logic        Reset;
    logic        Locked;
    logic [2:0]  ChipId;
    logic        ClrErrCnt;
    logic        TrigValid, EcrStb, BcrStb, PulseStb, CalStb, WrRegStb, RdRegStb;
    logic [3:0]  TrigPattern, PulseDur;
    logic [4:0]  TrigTag;
    logic [14:0] CalData;
    logic [8:0]  RegAddr;
    logic [15:0] RegData;
    logic [7:0]  ErrCnt;
    logic        fsm_state;

    int n_checks = 0;
    int n_fails  = 0;
    logic [6:0] stb;      // strobes on the sample cycle
    logic [6:0] gap_stb;  // any strobe seen in the following idle cycles

    cmd_frame_decoder_if frm ();

    cmd_frame_decoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .Reset(Reset), .frm(frm), .Locked(Locked), .ChipId(ChipId),
        .ClrErrCnt(ClrErrCnt), .TrigValid(TrigValid), .TrigPattern(TrigPattern),
        .TrigTag(TrigTag), .EcrStb(EcrStb), .BcrStb(BcrStb), .PulseStb(PulseStb),
        .PulseDur(PulseDur), .CalStb(CalStb), .CalData(CalData), .WrRegStb(WrRegStb),
        .RdRegStb(RdRegStb), .RegAddr(RegAddr), .RegData(RegData), .ErrCnt(ErrCnt),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] strobes();
        return {TrigValid, EcrStb, BcrStb, PulseStb, CalStb, WrRegStb, RdRegStb};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [15:0] f, input logic clr);
        @(negedge clk);
        frm.SyncData     = f;
        frm.SyncDataLoad = 1'b1;
        ClrErrCnt        = clr;
        @(negedge clk);
        frm.SyncDataLoad = 1'b0;
        ClrErrCnt        = 1'b0;
        stb     = strobes();
        gap_stb = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            gap_stb = gap_stb | strobes();
        end
    endtask

    initial begin
        Reset = 1'b1; Locked = 1'b1; ChipId = 3'd3; ClrErrCnt = 1'b0;
        frm.SyncData = 16'h0000; frm.SyncDataLoad = 1'b0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_strobes", strobes(), 7'b0);
        check("rst_errcnt", ErrCnt, 0);
        check("rst_state", fsm_state, 0);
        check("rst_fields", {RegAddr, RegData, CalData}, 0);

        // ECR: one-cycle strobe right after the load
        send_frame(16'h5A5A, 1'b0);
        check("ecr_stb", stb, 7'b0100000);
        check("ecr_width", gap_stb, 7'b0);

        // WRREG to chip 0 (we are chip 3): dropped silently
        send_frame(16'h6666, 1'b0);
        send_frame(16'h6A6C, 1'b0);
        send_frame(16'h7274, 1'b0);
        send_frame(16'h8BD4, 1'b0);
        check("wr_noaddr_stb", stb, 7'b0);
        check("wr_noaddr_err", ErrCnt, 0);

        // WRREG broadcast: syms 20,0,3,4,5,31
        send_frame(16'h6666, 1'b0);
        send_frame(16'hB16A, 1'b0);
        send_frame(16'h7274, 1'b0);
        send_frame(16'h8BD4, 1'b0);
        check("wr_bc_stb", stb, 7'b0000010);
        check("wr_bc_addr", RegAddr, 9'h001);
        check("wr_bc_data", RegData, 16'h90BF);

        // WRREG long-write mode (sym0=21): dropped with an error
        send_frame(16'h6666, 1'b0);
        send_frame(16'hB26A, 1'b0);
        send_frame(16'h7274, 1'b0);
        send_frame(16'h8BD4, 1'b0);
        check("wr_mode1_stb", stb, 7'b0);
        check("wr_mode1_err", ErrCnt, 1);
        check("wr_mode1_hold", RegData, 16'h90BF);

        // CAL with an interleaved trigger
        send_frame(16'h6363, 1'b0);
        send_frame(16'hB16A, 1'b0);
        send_frame(16'h2B6C, 1'b0);
        check("cal_trig_stb", stb, 7'b1000000);
        check("cal_trig_pat", TrigPattern, 4'd1);
        check("cal_trig_tag", TrigTag, 5'd1);
        check("cal_trig_state", fsm_state, 1);
        send_frame(16'h7274, 1'b0);
        check("cal_stb", stb, 7'b0000100);
        check("cal_data", CalData, 15'h0064);
        check("cal_regaddr_hold", RegAddr, 9'h001);

        // PULSE addressed by chip id (sym0=6), NOOP in between
        send_frame(16'h5C5C, 1'b0);
        send_frame(16'h6969, 1'b0);
        check("pulse_noop_state", fsm_state, 1);
        send_frame(16'h8D74, 1'b0);
        check("pulse_stb", stb, 7'b0001000);
        check("pulse_dur", PulseDur, 4'd4);

        // RDREG complete: syms 20,28,31,0
        send_frame(16'h6565, 1'b0);
        send_frame(16'hB1CC, 1'b0);
        send_frame(16'hD46A, 1'b0);
        check("rd_stb", stb, 7'b0000001);
        check("rd_addr", RegAddr, 9'h1CF);

        // RDREG aborted by BCR
        send_frame(16'h6565, 1'b0);
        send_frame(16'hB1CC, 1'b0);
        send_frame(16'h5959, 1'b0);
        check("abort_stb", stb, 7'b0010000);
        check("abort_err", ErrCnt, 2);
        check("abort_state", fsm_state, 0);

        // data frame in IDLE
        send_frame(16'h7274, 1'b0);
        check("idle_data_stb", stb, 7'b0);
        check("idle_data_err", ErrCnt, 3);

        // saturation
        @(negedge clk); ClrErrCnt = 1'b1;
        @(negedge clk); ClrErrCnt = 1'b0;
        check("clr_err", ErrCnt, 0);
        for (int i = 0; i < 255; i++) send_frame(16'h0000, 1'b0);
        check("sat_255", ErrCnt, 255);
        send_frame(16'h0000, 1'b0);
        check("sat_hold", ErrCnt, 255);
        send_frame(16'h0000, 1'b1);
        check("clr_priority", ErrCnt, 0);

        // Locked=0 during WRREG collection
        send_frame(16'h6666, 1'b0);
        send_frame(16'hB16A, 1'b0);
        Locked = 1'b0;
        @(negedge clk);
        check("unlock_state", fsm_state, 0);
        send_frame(16'h7274, 1'b0);
        send_frame(16'h8BD4, 1'b0);
        check("unlock_stb", stb | gap_stb, 7'b0);
        check("unlock_err", ErrCnt, 0);
        check("unlock_state2", fsm_state, 0);
        Locked = 1'b1;

        // Reset mid-CAL discards the partial command
        send_frame(16'h6363, 1'b0);
        send_frame(16'hB16A, 1'b0);
        check("pre_reset_state", fsm_state, 1);
        @(negedge clk); Reset = 1'b1;
        @(negedge clk); Reset = 1'b0;
        check("reset_mid_state", fsm_state, 0);
        check("reset_mid_cal", CalData, 0);
        send_frame(16'h7274, 1'b0);
        check("reset_mid_stb", stb, 7'b0);
        check("reset_mid_err", ErrCnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
